countdown_timer: RTL and testbench

Parametrised countdown timer for the clock project's countdown mode. Edits an HH:MM:SS preset with the up/down/left/right buttons and runs it down once per second. Supports pause/resume, reload to preset and an expiry flag. Drives the same packed BCD display word and cursor-state code as the existing countdown setter, so the display mux and blink logic connect unchanged.

---
 rtl/countdown_timer.sv | 242 ++++++++++++++++++++++++
 tb/tb_countdown_timer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// HH:MM:SS countdown timer with button editing, pause/resume, reload and expiry flag.
// Define COUNTDOWN_REPEAT_EN to enable auto-repeat of held up/down buttons.
module countdown_timer #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned HOLD_CYC   = 2500000,
    parameter int unsigned LONG_CYC   = 200000000,
    parameter int unsigned REPEAT_CYC = 25000000,
    parameter int unsigned HR10_MAX   = 9,
    parameter int unsigned MODE_ID    = 7,
    parameter logic [23:0] INIT_BCD   = 24'h194954
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        start,
    input  logic        modify,
    input  logic [3:0]  mode,
    output logic [31:0] tmp,
    output logic [3:0]  state,
    output logic        running,
    output logic        expired
);

    localparam int unsigned CW = 32;
    localparam int unsigned NB = 5;
    localparam logic [CW-1:0] HOLD_V  = CW'(HOLD_CYC);
    localparam logic [CW-1:0] LONG_V  = CW'(LONG_CYC);
    localparam logic [CW-1:0] PRE_MAX = CW'(CLK_HZ - 1);
`ifdef COUNTDOWN_REPEAT_EN
    localparam logic [CW-1:0] REP_V   = CW'(REPEAT_CYC);
    localparam logic [CW-1:0] UD_SAT  = '1;
`else
    localparam logic [CW-1:0] UD_SAT  = LONG_V;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} fsm_t;

    fsm_t          r_fsm;
    logic [23:0]   r_time;
    logic [23:0]   r_preset;
    logic [2:0]    r_cursor;
    logic [CW-1:0] r_pre;
    logic          r_running;
    logic          r_expired;
    logic [CW-1:0] r_cnt [NB];
    logic          r_long_seen;

    logic [NB-1:0] w_btn;
    logic [NB-1:0] w_ev;
    logic [1:0]    w_rep;
    logic          w_sel;
    logic          w_long;
    logic          w_edit_act;
    logic          w_edit_ok;
    logic          w_inc;
    logic          w_dec;
    logic          w_mvl;
    logic          w_mvr;
    logic [23:0]   w_time_edit;
    logic [23:0]   w_time_dec;

    function automatic logic [3:0] dig_max(input int i);
        case (i)
            1, 3:    return 4'd5;
            5:       return 4'(HR10_MAX);
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [3:0] edit_digit(input logic [3:0] d, input logic [3:0] mx,
                                              input logic inc);
        if (inc) return (d >= mx) ? 4'd0 : d + 4'd1;
        return (d == 4'd0 || d > mx) ? mx : d - 4'd1;
    endfunction

    // One-second BCD decrement; each digit borrows only when it wraps.
    function automatic logic [23:0] bcd_dec(input logic [23:0] t);
        logic [23:0] r;
        logic        b;
        r = t;
        b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (b) begin
                if (t[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = dig_max(i);
                end else begin
                    r[4*i +: 4] = t[4*i +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign w_btn = {start, right, left, down, up};
    assign w_sel = (mode == 4'(MODE_ID));

    // Per-button hold counters; up/down saturate higher when auto-repeat is built in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
            r_long_seen <= 1'b0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (!w_btn[i])
                    r_cnt[i] <= '0;
                else if (r_cnt[i] != ((i < 2) ? UD_SAT : LONG_V))
                    r_cnt[i] <= r_cnt[i] + CW'(1);
            end
            r_long_seen <= start && (r_cnt[4] == LONG_V);
        end
    end

`ifdef COUNTDOWN_REPEAT_EN
    logic [CW-1:0] r_ph [2];

    // Phase tracks (count - HOLD_CYC) mod REPEAT_CYC once the hold threshold is passed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) r_ph[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!w_btn[i] || r_cnt[i] < HOLD_V)
                    r_ph[i] <= '0;
                else if (r_ph[i] == REP_V - CW'(1))
                    r_ph[i] <= '0;
                else
                    r_ph[i] <= r_ph[i] + CW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) w_rep[i] = (r_cnt[i] > HOLD_V) && (r_ph[i] == '0);
    end
`else
    assign w_rep = 2'b00;
`endif

    always_comb begin
        for (int i = 0; i < NB; i++) w_ev[i] = w_sel && (r_cnt[i] == HOLD_V);
        w_ev[0] = w_ev[0] || (w_sel && w_rep[0]);
        w_ev[1] = w_ev[1] || (w_sel && w_rep[1]);
    end

    assign w_long     = w_sel && (r_cnt[4] == LONG_V) && !r_long_seen;
    assign w_edit_act = w_sel && modify && (r_fsm == S_IDLE);
    assign w_edit_ok  = w_edit_act && !w_ev[4];
    assign w_inc      = w_edit_ok && w_ev[0] && !w_ev[1];
    assign w_dec      = w_edit_ok && w_ev[1] && !w_ev[0];
    assign w_mvl      = w_edit_ok && w_ev[2] && !w_ev[3];
    assign w_mvr      = w_edit_ok && w_ev[3] && !w_ev[2];

    always_comb begin
        w_time_edit = r_time;
        for (int i = 0; i < 6; i++) begin
            if (r_cursor == 3'(i + 1))
                w_time_edit[4*i +: 4] = edit_digit(r_time[4*i +: 4], dig_max(i), w_inc);
        end
    end

    assign w_time_dec = bcd_dec(r_time);

    // Run-state FSM, prescaler, cursor and time/preset registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm     <= S_IDLE;
            r_time    <= INIT_BCD;
            r_preset  <= INIT_BCD;
            r_cursor  <= 3'd1;
            r_pre     <= '0;
            r_running <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            if (w_mvl)
                r_cursor <= (r_cursor == 3'd6) ? 3'd1 : r_cursor + 3'd1;
            else if (w_mvr)
                r_cursor <= (r_cursor == 3'd1) ? 3'd6 : r_cursor - 3'd1;

            case (r_fsm)
                S_IDLE: begin
                    if (w_ev[4] && r_time != 24'd0) begin
                        r_fsm     <= S_RUN;
                        r_pre     <= '0;
                        r_running <= 1'b1;
                    end else if (w_inc || w_dec) begin
                        r_time   <= w_time_edit;
                        r_preset <= w_time_edit;
                    end
                end
                S_RUN: begin
                    if (w_long) begin
                        r_fsm     <= S_IDLE;
                        r_time    <= r_preset;
                        r_pre     <= '0;
                        r_running <= 1'b0;
                    end else if (w_ev[4]) begin
                        r_fsm     <= S_PAUSE;
                        r_running <= 1'b0;
                    end else if (r_pre == PRE_MAX) begin
                        r_pre  <= '0;
                        r_time <= w_time_dec;
                        if (w_time_dec == 24'd0) begin
                            r_fsm     <= S_DONE;
                            r_running <= 1'b0;
                            r_expired <= 1'b1;
                        end
                    end else begin
                        r_pre <= r_pre + CW'(1);
                    end
                end
                S_PAUSE: begin
                    if (w_long) begin
                        r_fsm  <= S_IDLE;
                        r_time <= r_preset;
                        r_pre  <= '0;
                    end else if (w_ev[4]) begin
                        r_fsm     <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_ev[4]) begin
                        r_fsm     <= S_IDLE;
                        r_time    <= r_preset;
                        r_expired <= 1'b0;
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign tmp     = {r_time[23:16], 4'hF, r_time[15:8], 4'hF, r_time[7:0]};
    assign state   = w_edit_act ? {1'b0, r_cursor} : 4'd0;
    assign running = r_running;
    assign expired = r_expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with short timing parameters.
module tb_countdown_timer;

    logic        clk;
    logic        rst_n;
    logic        up, down, left, right, start, modify;
    logic [3:0]  mode;
    logic [31:0] tmp;
    logic [3:0]  state;
    logic        running, expired;

    int checks;
    int errors;

    localparam logic [4:0] M_UP = 5'b00001;
    localparam logic [4:0] M_DN = 5'b00010;
    localparam logic [4:0] M_LF = 5'b00100;
    localparam logic [4:0] M_RT = 5'b01000;
    localparam logic [4:0] M_ST = 5'b10000;

    typedef struct {
        logic [4:0]  mask;
        logic [31:0] exp_tmp;
        logic [3:0]  exp_state;
    } vec_t;

    vec_t tbl [25];

    countdown_timer #(
        .CLK_HZ(10), .HOLD_CYC(4), .LONG_CYC(40), .REPEAT_CYC(8),
        .HR10_MAX(9), .MODE_ID(7), .INIT_BCD(24'h194954)
    ) dut (
        .clk(clk), .rst_n(rst_n), .up(up), .down(down), .left(left), .right(right),
        .start(start), .modify(modify), .mode(mode), .tmp(tmp), .state(state),
        .running(running), .expired(expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] m);
        {start, right, left, down, up} = m;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Hold a button set for one qualified press, then release for one cycle.
    task automatic press(input logic [4:0] m);
        drive(m);
        cyc(5);
    endtask

    task automatic release_btn();
        drive(5'b0);
        cyc(1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0]  = '{M_UP,        32'h19F49F55, 4'd1};
        tbl[1]  = '{M_UP,        32'h19F49F56, 4'd1};
        tbl[2]  = '{M_UP,        32'h19F49F57, 4'd1};
        tbl[3]  = '{M_UP,        32'h19F49F58, 4'd1};
        tbl[4]  = '{M_UP,        32'h19F49F59, 4'd1};
        tbl[5]  = '{M_UP,        32'h19F49F50, 4'd1};
        tbl[6]  = '{M_LF,        32'h19F49F50, 4'd2};
        tbl[7]  = '{M_UP,        32'h19F49F00, 4'd2};
        tbl[8]  = '{M_LF,        32'h19F49F00, 4'd3};
        tbl[9]  = '{M_UP,        32'h19F40F00, 4'd3};
        tbl[10] = '{M_LF,        32'h19F40F00, 4'd4};
        tbl[11] = '{M_UP,        32'h19F50F00, 4'd4};
        tbl[12] = '{M_UP,        32'h19F00F00, 4'd4};
        tbl[13] = '{M_LF,        32'h19F00F00, 4'd5};
        tbl[14] = '{M_UP,        32'h10F00F00, 4'd5};
        tbl[15] = '{M_UP,        32'h11F00F00, 4'd5};
        tbl[16] = '{M_LF,        32'h11F00F00, 4'd6};
        tbl[17] = '{M_DN,        32'h01F00F00, 4'd6};
        tbl[18] = '{M_DN,        32'h91F00F00, 4'd6};
        tbl[19] = '{M_UP,        32'h01F00F00, 4'd6};
        tbl[20] = '{M_UP | M_DN, 32'h01F00F00, 4'd6};
        tbl[21] = '{M_LF,        32'h01F00F00, 4'd1};
        tbl[22] = '{M_RT,        32'h01F00F00, 4'd6};
        tbl[23] = '{M_LF | M_RT, 32'h01F00F00, 4'd6};
        tbl[24] = '{M_LF,        32'h01F00F00, 4'd1};

        rst_n  = 1'b0;
        drive(5'b0);
        mode   = 4'd7;
        modify = 1'b1;
        #12;
        chk("reset_tmp", tmp, 32'h19F49F54);
        chk("reset_state", 32'(state), 32'd1);
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_expired", 32'(expired), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First start: RUN registers on the edge after the counter reaches HOLD.
        drive(M_ST);
        cyc(4);
        chk("start_not_yet", 32'(running), 32'd0);
        cyc(1);
        chk("start_running", 32'(running), 32'd1);
        chk("start_tmp", tmp, 32'h19F49F54);
        chk("run_state_hidden", 32'(state), 32'd0);
        drive(5'b0);
        cyc(9);
        chk("pre_first_tick", tmp, 32'h19F49F54);
        cyc(1);
        chk("first_tick", tmp, 32'h19F49F53);

        // Long start: pause at count 4, reload and IDLE at count 40.
        drive(M_ST);
        cyc(5);
        chk("long_pause_run", 32'(running), 32'd0);
        chk("long_pause_tmp", tmp, 32'h19F49F53);
        cyc(35);
        chk("long_before_state", 32'(state), 32'd0);
        cyc(1);
        chk("long_idle_state", 32'(state), 32'd1);
        chk("long_reload_tmp", tmp, 32'h19F49F54);
        release_btn();

        // Edit table: build preset 010000 and exercise wraps and conflicts.
        for (int i = 0; i < 25; i++) begin
            press(tbl[i].mask);
            chk($sformatf("edit%0d_tmp", i), tmp, tbl[i].exp_tmp);
            chk($sformatf("edit%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
            release_btn();
        end

        // Borrow chain from 010000.
        press(M_ST);
        chk("borrow_run", 32'(running), 32'd1);
        drive(5'b0);
        cyc(9);
        chk("borrow_pre", tmp, 32'h01F00F00);
        cyc(1);
        chk("borrow_tick", tmp, 32'h00F59F59);

        // Pause with 4 prescaler counts elapsed; next tick 6 cycles after resume.
        press(M_ST);
        chk("pause_run", 32'(running), 32'd0);
        drive(5'b0);
        cyc(45);
        chk("pause_hold_tmp", tmp, 32'h00F59F59);
        press(M_ST);
        chk("resume_run", 32'(running), 32'd1);
        drive(5'b0);
        cyc(5);
        chk("resume_pre", tmp, 32'h00F59F59);
        cyc(1);
        chk("resume_tick", tmp, 32'h00F59F58);

        // Mode deselected while running: start ignored, count continues.
        mode = 4'd3;
        press(M_ST);
        chk("mode3_run", 32'(running), 32'd1);
        drive(5'b0);
        cyc(5);
        chk("mode3_tick", tmp, 32'h00F59F57);
        mode = 4'd7;
        drive(M_ST);
        cyc(41);
        chk("reload_state", 32'(state), 32'd1);
        chk("reload_tmp", tmp, 32'h01F00F00);
        chk("reload_run", 32'(running), 32'd0);
        release_btn();

        // Mode deselected in IDLE: no edit, no start, cursor hidden.
        mode = 4'd3;
        #1;
        chk("mode3_state", 32'(state), 32'd0);
        press(M_UP);
        release_btn();
        chk("mode3_edit", tmp, 32'h01F00F00);
        press(M_ST);
        chk("mode3_start", 32'(running), 32'd0);
        release_btn();
        mode = 4'd7;
        #1;
        chk("mode7_state", 32'(state), 32'd1);

        // Expiry from 000001.
        press(M_UP);
        chk("exp_s1", tmp, 32'h01F00F01);
        release_btn();
        press(M_RT);
        release_btn();
        press(M_RT);
        chk("exp_cursor", 32'(state), 32'd5);
        release_btn();
        press(M_DN);
        chk("exp_h1", tmp, 32'h00F00F01);
        release_btn();
        press(M_ST);
        chk("exp_run", 32'(running), 32'd1);
        drive(5'b0);
        cyc(9);
        chk("exp_pre_tmp", tmp, 32'h00F00F01);
        chk("exp_pre_flag", 32'(expired), 32'd0);
        cyc(1);
        chk("exp_tmp", tmp, 32'h00F00F00);
        chk("exp_flag", 32'(expired), 32'd1);
        chk("exp_running", 32'(running), 32'd0);
        press(M_ST);
        chk("done_clear", 32'(expired), 32'd0);
        chk("done_reload", tmp, 32'h00F00F01);
        chk("done_idle", 32'(state), 32'd5);
        release_btn();

        // Start with time 000000 in IDLE is ignored.
        press(M_LF);
        release_btn();
        press(M_LF);
        release_btn();
        press(M_DN);
        chk("zero_time", tmp, 32'h00F00F00);
        release_btn();
        press(M_ST);
        chk("zero_start_run", 32'(running), 32'd0);
        chk("zero_start_state", 32'(state), 32'd1);
        release_btn();

        // Held up for 20 cycles on s1=0.
        drive(M_UP);
        cyc(20);
        drive(5'b0);
        cyc(1);
`ifdef COUNTDOWN_REPEAT_EN
        chk("hold_up", tmp, 32'h00F00F03);
`else
        chk("hold_up", tmp, 32'h00F00F01);
`endif

        // Asynchronous reset mid-count.
        press(M_ST);
        chk("rst_pre_run", 32'(running), 32'd1);
        drive(5'b0);
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_tmp", tmp, 32'h19F49F54);
        chk("rst_mid_run", 32'(running), 32'd0);
        chk("rst_mid_exp", 32'(expired), 32'd0);
        chk("rst_mid_state", 32'(state), 32'd1);
        #20 rst_n = 1'b1;
        #20;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
